// File: rtl/boot_loader_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot sequencer: state encoding, instruction
// source selector values and the wrapping word-address adder used to form
// ROM / I$ addresses from a base and the running word index.
// -----------------------------------------------------------------------------
package boot_pkg;

  // Two-bit boot state. The values are visible to firmware/debug tooling,
  // so they are fixed explicitly rather than left to the tool.
  typedef enum logic [1:0] {
    COPY     = 2'd0,
    VERIFY   = 2'd1,
    DONE     = 2'd2,
    FALLBACK = 2'd3
  } boot_state_e;

  // Instruction source presented to the core fetch mux.
  localparam logic SRC_ICACHE = 1'b0;
  localparam logic SRC_ROM    = 1'b1;

  // Word address width ([31:2] of a byte address).
  localparam int unsigned WADDR_W = 30;

  // Base + offset in word-address space. Overflow past 2^30 wraps silently,
  // which lets an image straddle the top of the address map.
  function automatic logic [WADDR_W-1:0] addr_add(
    input logic [WADDR_W-1:0] base,
    input logic [WADDR_W-1:0] offset
  );
    addr_add = base + offset;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl
// Boot sequencer between internal ROM, the instruction cache and the core.
// Out of reset it holds the core in reset, copies a WORDS-long image from ROM
// into the I$, reads it back and compares against ROM. On a clean verify the
// core is released fetching from the I$; after MAX_RETRY failed re-copies the
// core is released fetching directly from ROM instead.
//
// Ports
//   clk_i        single clock
//   rst_i        asynchronous active-high reset
//   boot_req_i   level reboot request, honoured only in DONE / FALLBACK
//   core_addr_i  core fetch word address, passed through once booted
//   rom_addr_o   ROM word address
//   rom_data_i   ROM read data (combinational)
//   ic_addr_o    I$ word address
//   ic_wdata_o   I$ write data
//   ic_we_o      I$ write strobe, committed on the rising clock edge
//   ic_rdata_i   I$ read data (combinational)
//   core_rst_o   core reset, active-high
//   instr_sel_o  instruction source: 0 = I$, 1 = ROM
//   done_o       high in DONE
//   error_o      high in FALLBACK
// -----------------------------------------------------------------------------
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned WORDS     = 256,
  parameter logic [29:0] ROM_BASE  = 30'h0,
  parameter logic [29:0] IC_BASE   = 30'h0,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boot_req_i,
  input  logic [31:2] core_addr_i,
  output logic [31:2] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:2] ic_addr_o,
  output logic [31:0] ic_wdata_o,
  output logic        ic_we_o,
  input  logic [31:0] ic_rdata_i,
  output logic        core_rst_o,
  output logic        instr_sel_o,
  output logic        done_o,
  output logic        error_o
);

  // A single-word image still needs a 1-bit counter.
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  boot_state_e      state;
  boot_state_e      state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [RTY_W-1:0] retry;
  logic [RTY_W-1:0] retry_nxt;

  logic             idx_last;
  logic             mismatch;
  logic [29:0]      idx_ext;
  logic [29:0]      seq_rom_addr;
  logic [29:0]      seq_ic_addr;

  assign idx_last = (idx == IDX_LAST);
  assign mismatch = (ic_rdata_i != rom_data_i);
  assign idx_ext  = {{(30 - IDX_W){1'b0}}, idx};

  assign seq_rom_addr = addr_add(ROM_BASE, idx_ext);
  assign seq_ic_addr  = addr_add(IC_BASE, idx_ext);

  // ---------------------------------------------------------------------------
  // State, word counter and retry counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= COPY;
      idx   <= '0;
      retry <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;

    case (state)
      COPY: begin
        if (idx_last) begin
          idx_nxt   = '0;
          state_nxt = VERIFY;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      VERIFY: begin
        // A mismatch aborts the rest of the pass straight away; there is no
        // point reading further words of an image that is about to be
        // rewritten or abandoned.
        if (mismatch) begin
          idx_nxt = '0;
          if (retry < RTY_MAX) begin
            retry_nxt = retry + 1'b1;
            state_nxt = COPY;
          end else begin
            state_nxt = FALLBACK;
          end
        end else if (idx_last) begin
          idx_nxt   = '0;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      DONE, FALLBACK: begin
        // Reboot starts from a clean slate, including the retry budget.
        if (boot_req_i) begin
          idx_nxt   = '0;
          retry_nxt = '0;
          state_nxt = COPY;
        end
      end

      default: begin
        idx_nxt   = '0;
        retry_nxt = '0;
        state_nxt = COPY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs. The defaults describe the sequencing states; the core is
  // kept in reset and pointed at ROM until an image has been accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_addr_o  = seq_rom_addr;
    ic_addr_o   = seq_ic_addr;
    ic_wdata_o  = rom_data_i;
    ic_we_o     = 1'b0;
    core_rst_o  = 1'b1;
    instr_sel_o = SRC_ROM;
    done_o      = 1'b0;
    error_o     = 1'b0;

    case (state)
      COPY: begin
        ic_we_o = 1'b1;
      end

      VERIFY: begin
        ic_we_o = 1'b0;
      end

      DONE: begin
        rom_addr_o  = core_addr_i;
        ic_addr_o   = core_addr_i;
        core_rst_o  = 1'b0;
        instr_sel_o = SRC_ICACHE;
        done_o      = 1'b1;
      end

      FALLBACK: begin
        rom_addr_o  = core_addr_i;
        ic_addr_o   = core_addr_i;
        core_rst_o  = 1'b0;
        instr_sel_o = SRC_ROM;
        error_o     = 1'b1;
      end

      default: begin
        ic_we_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl
// Bench for boot_loader_ctrl. Two instances: a 4-word image whose ROM base
// sits just below the top of the address map (addresses wrap), and a 1-word
// image at the very last ROM word. A hashed ROM and a small I$ model with
// optional transient / stuck-at faults feed each instance. The expected
// cycle-by-cycle sequence is derived per pass from the fault kind: a pass is
// WORDS copy cycles followed by verify cycles up to and including the first
// bad word (or all words when clean).
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

  localparam int          W_A        = 4;
  localparam logic [29:0] ROM_BASE_A = 30'h3FFFFFFE;
  localparam logic [29:0] IC_BASE_A  = 30'h100;
  localparam int          RETRY_A    = 2;

  localparam logic [29:0] ROM_BASE_B = 30'h3FFFFFFF;
  localparam logic [29:0] IC_BASE_B  = 30'h40;

  localparam int PH_COPY = 0, PH_VERIFY = 1, PH_DONE = 2, PH_FALLBACK = 3;

  typedef struct {
    int ph;
    int k;
  } exp_t;

  logic clk;

  logic        rst_a, boot_req_a;
  logic [31:2] core_addr_a, rom_addr_a, ic_addr_a;
  logic [31:0] rom_data_a, ic_wdata_a, ic_rdata_a;
  logic        ic_we_a, core_rst_a, instr_sel_a, done_a, error_a;

  logic        rst_b, boot_req_b;
  logic [31:2] core_addr_b, rom_addr_b, ic_addr_b;
  logic [31:0] rom_data_b, ic_wdata_b, ic_rdata_b;
  logic        ic_we_b, core_rst_b, instr_sel_b, done_b, error_b;

  logic [31:0] rom_seed;
  int          fault_mode;  // 0 none, 1 transient on first write, 2 stuck at 0
  int          fault_word;
  int          arm_id;
  int          used_id;

  int total;
  int bad;

  boot_loader_ctrl #(
    .WORDS(W_A), .ROM_BASE(ROM_BASE_A), .IC_BASE(IC_BASE_A), .MAX_RETRY(RETRY_A)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .boot_req_i(boot_req_a), .core_addr_i(core_addr_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a), .ic_addr_o(ic_addr_a),
    .ic_wdata_o(ic_wdata_a), .ic_we_o(ic_we_a), .ic_rdata_i(ic_rdata_a),
    .core_rst_o(core_rst_a), .instr_sel_o(instr_sel_a), .done_o(done_a),
    .error_o(error_a)
  );

  boot_loader_ctrl #(
    .WORDS(1), .ROM_BASE(ROM_BASE_B), .IC_BASE(IC_BASE_B), .MAX_RETRY(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .boot_req_i(boot_req_b), .core_addr_i(core_addr_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b), .ic_addr_o(ic_addr_b),
    .ic_wdata_o(ic_wdata_b), .ic_we_o(ic_we_b), .ic_rdata_i(ic_rdata_b),
    .core_rst_o(core_rst_b), .instr_sel_o(instr_sel_b), .done_o(done_b),
    .error_o(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: every word is a nonzero hash of its address and a seed.
  function automatic logic [31:0] rom_word(input logic [31:2] a, input logic [31:0] seed);
    rom_word = ((({a, 2'b00}) * 32'h9E3779B1) ^ seed) | 32'h1;
  endfunction

  assign rom_data_a = rom_word(rom_addr_a, rom_seed);
  assign rom_data_b = rom_word(rom_addr_b, rom_seed);

  // I$ model for instance A: 4 words at IC_BASE_A.
  logic [31:0] ic_mem_a [4];
  logic [29:0] ic_off_a;
  assign ic_off_a = ic_addr_a - IC_BASE_A;

  always @(posedge clk) begin
    if (ic_we_a && ic_off_a < 30'd4) begin
      if (fault_mode == 1 && ic_off_a == 30'(fault_word) && used_id != arm_id) begin
        ic_mem_a[ic_off_a[1:0]] <= ic_wdata_a ^ 32'h0F0F_0000;
        used_id <= arm_id;
      end else begin
        ic_mem_a[ic_off_a[1:0]] <= ic_wdata_a;
      end
    end
  end

  always_comb begin
    ic_rdata_a = 32'hDEAD_BEEF;
    if (ic_off_a < 30'd4) begin
      if (fault_mode == 2 && ic_off_a == 30'(fault_word)) ic_rdata_a = 32'h0;
      else ic_rdata_a = ic_mem_a[ic_off_a[1:0]];
    end
  end

  // I$ model for instance B: a single word at IC_BASE_B.
  logic [31:0] ic_mem_b;
  always @(posedge clk) begin
    if (ic_we_b && ic_addr_b == IC_BASE_B) ic_mem_b <= ic_wdata_b;
  end
  assign ic_rdata_b = (ic_addr_b == IC_BASE_B) ? ic_mem_b : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_core_rst", 32'(core_rst_a), 32'd1);
    chk("rst_instr_sel", 32'(instr_sel_a), 32'd1);
    chk("rst_ic_we", 32'(ic_we_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_error", 32'(error_a), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr_a), 32'(ROM_BASE_A));
    chk("rst_ic_addr", 32'(ic_addr_a), 32'(IC_BASE_A));
  endtask

  task automatic chk_entry(input exp_t e);
    logic [29:0] er, ei;
    er = ROM_BASE_A + 30'(e.k);
    ei = IC_BASE_A + 30'(e.k);
    case (e.ph)
      PH_COPY, PH_VERIFY: begin
        chk(e.ph == PH_COPY ? "copy_we" : "verify_we", 32'(ic_we_a), (e.ph == PH_COPY) ? 32'd1 : 32'd0);
        chk("seq_rom_addr", 32'(rom_addr_a), 32'(er));
        chk("seq_ic_addr", 32'(ic_addr_a), 32'(ei));
        if (e.ph == PH_COPY) chk("copy_wdata", ic_wdata_a, rom_word(er, rom_seed));
        chk("seq_core_rst", 32'(core_rst_a), 32'd1);
        chk("seq_instr_sel", 32'(instr_sel_a), 32'd1);
        chk("seq_done", 32'(done_a), 32'd0);
        chk("seq_error", 32'(error_a), 32'd0);
      end
      default: begin
        chk("end_we", 32'(ic_we_a), 32'd0);
        chk("end_rom_addr", 32'(rom_addr_a), 32'(core_addr_a));
        chk("end_ic_addr", 32'(ic_addr_a), 32'(core_addr_a));
        chk("end_core_rst", 32'(core_rst_a), 32'd0);
        chk("end_instr_sel", 32'(instr_sel_a), (e.ph == PH_DONE) ? 32'd0 : 32'd1);
        chk("end_done", 32'(done_a), (e.ph == PH_DONE) ? 32'd1 : 32'd0);
        chk("end_error", 32'(error_a), (e.ph == PH_FALLBACK) ? 32'd1 : 32'd0);
      end
    endcase
  endtask

  // Walk one boot from COPY idx 0 to its final state. req_at pulses
  // boot_req_a for one cycle at that step; abort_at asserts rst_a mid-cycle.
  task automatic run_boot(input int mode, input int fw, input int req_at, input int abort_at);
    exp_t q[$];
    int   m;
    fault_mode = mode;
    fault_word = fw;
    arm_id++;
    for (int p = 0; p <= RETRY_A; p++) begin
      m = (mode == 0) ? -1 : (mode == 1) ? ((p == 0) ? fw : -1) : fw;
      for (int k = 0; k < W_A; k++) q.push_back('{PH_COPY, k});
      for (int k = 0; k < W_A && (m < 0 || k <= m); k++) q.push_back('{PH_VERIFY, k});
      if (m < 0) begin
        q.push_back('{PH_DONE, 0});
        break;
      end
      if (p == RETRY_A) q.push_back('{PH_FALLBACK, 0});
    end
    for (int i = 0; i < q.size(); i++) begin
      chk_entry(q[i]);
      if (i == abort_at) begin
        #2 rst_a = 1'b1;
        #1 chk_reset_a();
        @(negedge clk) rst_a = 1'b0;
        return;
      end
      if (i == q.size() - 1) begin
        for (int e = 0; e < 2; e++) begin
          @(posedge clk);
          #1 core_addr_a = 30'($urandom);
          #1 chk_entry(q[i]);
        end
        return;
      end
      if (i == req_at) boot_req_a = 1'b1;
      @(posedge clk);
      #1 boot_req_a = 1'b0;
    end
  endtask

  task automatic reboot_a();
    boot_req_a = 1'b1;
    @(posedge clk);
    #1 boot_req_a = 1'b0;
  endtask

  initial begin
    int fw;
    total = 0;
    bad = 0;
    arm_id = 0;
    fault_mode = 0;
    fault_word = 0;
    rom_seed = $urandom;
    rst_a = 1'b1;
    rst_b = 1'b1;
    boot_req_a = 1'b0;
    boot_req_b = 1'b0;
    core_addr_a = 30'($urandom);
    core_addr_b = 30'($urandom);

    #3 chk_reset_a();
    @(negedge clk) rst_a = 1'b0;

    // Clean boot; a boot request during COPY must not disturb it.
    run_boot(0, 0, 1, -1);

    // Reboot from DONE, then one transient fault; request during VERIFY ignored.
    reboot_a();
    fw = $urandom_range(0, W_A - 1);
    run_boot(1, fw, W_A + 1, -1);

    // Persistent fault: all retries used up, then FALLBACK.
    reboot_a();
    run_boot(2, 1, -1, -1);

    // Reset in the middle of the second copy pass, then the full retry budget again.
    reboot_a();
    fw = $urandom_range(0, W_A - 1);
    run_boot(2, fw, -1, W_A + fw + 1 + 2);
    run_boot(2, fw, -1, -1);

    // Randomized boots from whichever final state was reached.
    for (int r = 0; r < 5; r++) begin
      rom_seed = $urandom;
      reboot_a();
      run_boot(int'($urandom_range(0, 2)), int'($urandom_range(0, W_A - 1)), -1, -1);
    end

    // Single-word image at the last ROM word: one write, one verify, DONE at edge 2.
    #1 chk("b_rst_core_rst", 32'(core_rst_b), 32'd1);
    @(negedge clk) rst_b = 1'b0;
    chk("b_copy_we", 32'(ic_we_b), 32'd1);
    chk("b_copy_rom_addr", 32'(rom_addr_b), 32'(ROM_BASE_B));
    chk("b_copy_ic_addr", 32'(ic_addr_b), 32'(IC_BASE_B));
    chk("b_copy_wdata", ic_wdata_b, rom_word(ROM_BASE_B, rom_seed));
    @(posedge clk);
    #1 chk("b_verify_we", 32'(ic_we_b), 32'd0);
    chk("b_verify_core_rst", 32'(core_rst_b), 32'd1);
    chk("b_verify_done", 32'(done_b), 32'd0);
    @(posedge clk);
    #1 chk("b_done", 32'(done_b), 32'd1);
    chk("b_done_core_rst", 32'(core_rst_b), 32'd0);
    chk("b_done_instr_sel", 32'(instr_sel_b), 32'd0);
    chk("b_done_error", 32'(error_b), 32'd0);
    chk("b_done_rom_addr", 32'(rom_addr_b), 32'(core_addr_b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
